// File: rtl/fwd_arbiter.sv
// Round-robin arbiter sharing one packet forwarder among N_CORES filter cores.
// Offers the granted core's packet, routes the read port to it and returns done.
module fwd_arbiter #(
    parameter int N_CORES            = 4,
    parameter int SN_FWD_ADDR_WIDTH  = 8,
    parameter int SN_FWD_DATA_WIDTH  = 64,
    parameter int PLEN_WIDTH         = 32,
    parameter int IDX_W              = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_CORES-1:0]                     core_rdy_for_fwd,
    output logic [N_CORES-1:0]                     core_rdy_for_fwd_ack,
    input  logic [N_CORES*PLEN_WIDTH-1:0]          core_byte_len,
    output logic [SN_FWD_ADDR_WIDTH-1:0]           core_fwd_addr,
    output logic [N_CORES-1:0]                     core_fwd_rd_en,
    input  logic [N_CORES*SN_FWD_DATA_WIDTH-1:0]   core_fwd_rd_data,
    input  logic [N_CORES-1:0]                     core_fwd_rd_data_vld,
    output logic [N_CORES-1:0]                     core_fwd_done,
    output logic                                   rdy_for_fwd,
    input  logic                                   rdy_for_fwd_ack,
    output logic [PLEN_WIDTH-1:0]                  fwd_byte_len,
    input  logic [SN_FWD_ADDR_WIDTH-1:0]           fwd_addr,
    input  logic                                   fwd_rd_en,
    output logic [SN_FWD_DATA_WIDTH-1:0]           fwd_rd_data,
    output logic                                   fwd_rd_data_vld,
    input  logic                                   fwd_done,
    output logic [IDX_W-1:0]                       grant_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IDX_W-1:0]        rr_ptr_r;
    logic [IDX_W-1:0]        rr_ptr_nxt_s;
    logic [IDX_W-1:0]        grant_r;
    logic [IDX_W-1:0]        grant_nxt_s;
    logic [PLEN_WIDTH-1:0]   len_r;
    logic [PLEN_WIDTH-1:0]   len_nxt_s;
    logic [IDX_W-1:0]        pick_s;
    logic                    pick_vld_s;
    logic                    active_s;

    // Modular add over core indices; both operands are below N_CORES so one
    // conditional subtraction is enough, which also covers non-power-of-two counts.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W:0]   off);
        logic [IDX_W+1:0] sum;
        sum = {2'b00, base} + {1'b0, off};
        sum = (sum >= (IDX_W+2)'(N_CORES)) ? (sum - (IDX_W+2)'(N_CORES)) : sum;
        return sum[IDX_W-1:0];
    endfunction

    // Round-robin search: scan offsets high to low so the nearest request from rr_ptr wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand       = '0;
        pick_s     = '0;
        pick_vld_s = 1'b0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr_r, (IDX_W+1)'(i));
            if (core_rdy_for_fwd[cand]) begin
                pick_s     = cand;
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Next-state logic plus the zero-latency ack and done pulses to the granted core.
    always_comb begin
        state_nxt_s          = state_r;
        rr_ptr_nxt_s         = rr_ptr_r;
        grant_nxt_s          = grant_r;
        len_nxt_s            = len_r;
        core_rdy_for_fwd_ack = '0;
        core_fwd_done        = '0;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) begin
                    grant_nxt_s = pick_s;
                    len_nxt_s   = core_byte_len[pick_s*PLEN_WIDTH +: PLEN_WIDTH];
                    state_nxt_s = OFFER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OFFER: begin
                // A withdrawn request beats a simultaneous ack: never ack a core that let go.
                if (!core_rdy_for_fwd[grant_r]) begin
                    state_nxt_s = IDLE;
                end else if (rdy_for_fwd_ack) begin
                    core_rdy_for_fwd_ack[grant_r] = 1'b1;
                    state_nxt_s                   = BUSY;
                end else begin
                    state_nxt_s = OFFER;
                end
            end
            BUSY: begin
                if (fwd_done) begin
                    core_fwd_done[grant_r] = 1'b1;
                    rr_ptr_nxt_s           = wrap_add(grant_r, (IDX_W+1)'(1));
                    state_nxt_s            = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and grant registers; reset abandons any grant without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            grant_r  <= '0;
            len_r    <= '0;
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            grant_r  <= grant_nxt_s;
            len_r    <= len_nxt_s;
        end
    end

    assign active_s      = (state_r == OFFER) || (state_r == BUSY);
    assign rdy_for_fwd   = (state_r == OFFER);
    assign fwd_byte_len  = len_r;
    assign grant_idx     = grant_r;
    assign core_fwd_addr = fwd_addr;

    // Read-port routing: only the granted core sees the enable and only its data returns.
    always_comb begin
        core_fwd_rd_en  = '0;
        fwd_rd_data     = '0;
        fwd_rd_data_vld = 1'b0;
        if (active_s) begin
            core_fwd_rd_en[grant_r] = fwd_rd_en;
            fwd_rd_data             = core_fwd_rd_data[grant_r*SN_FWD_DATA_WIDTH +: SN_FWD_DATA_WIDTH];
            fwd_rd_data_vld         = core_fwd_rd_data_vld[grant_r];
        end else begin
            core_fwd_rd_en  = '0;
            fwd_rd_data     = '0;
            fwd_rd_data_vld = 1'b0;
        end
    end

endmodule

// File: tb/tb_fwd_arbiter.sv
// Scoreboard bench for fwd_arbiter: expected grants and read beats are queued
// as stimulus is driven and compared when the arbiter produces them.
module tb_fwd_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int LW = 32;

    typedef struct {
        int idx;
        int len;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      core_rdy_for_fwd;
    logic [N-1:0]      core_rdy_for_fwd_ack;
    logic [N*LW-1:0]   core_byte_len;
    logic [AW-1:0]     core_fwd_addr;
    logic [N-1:0]      core_fwd_rd_en;
    logic [N*DW-1:0]   core_fwd_rd_data;
    logic [N-1:0]      core_fwd_rd_data_vld;
    logic [N-1:0]      core_fwd_done;
    logic              rdy_for_fwd;
    logic              rdy_for_fwd_ack;
    logic [LW-1:0]     fwd_byte_len;
    logic [AW-1:0]     fwd_addr;
    logic              fwd_rd_en;
    logic [DW-1:0]     fwd_rd_data;
    logic              fwd_rd_data_vld;
    logic              fwd_done;
    logic [1:0]        grant_idx;

    logic [LW-1:0]     lens [N];
    logic [3:0]        p_en [N];
    logic [AW-1:0]     p_addr [N][4];
    logic              noise;
    logic              route_chk;

    exp_t              exp_q [$];
    logic [DW-1:0]     rd_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int m_rr     = 0;
    int ack_cnt  [N] = '{default: 0};
    int done_cnt [N] = '{default: 0};
    int exp_acks [N] = '{default: 0};
    int exp_dones[N] = '{default: 0};
    int waits    [N] = '{default: 0};
    int max_wait = 0;
    int overlap  = 0;
    int rogue_en = 0;
    int en_beats = 0;

    fwd_arbiter #(
        .N_CORES(N), .SN_FWD_ADDR_WIDTH(AW), .SN_FWD_DATA_WIDTH(DW), .PLEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .core_rdy_for_fwd(core_rdy_for_fwd), .core_rdy_for_fwd_ack(core_rdy_for_fwd_ack),
        .core_byte_len(core_byte_len), .core_fwd_addr(core_fwd_addr),
        .core_fwd_rd_en(core_fwd_rd_en), .core_fwd_rd_data(core_fwd_rd_data),
        .core_fwd_rd_data_vld(core_fwd_rd_data_vld), .core_fwd_done(core_fwd_done),
        .rdy_for_fwd(rdy_for_fwd), .rdy_for_fwd_ack(rdy_for_fwd_ack),
        .fwd_byte_len(fwd_byte_len), .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en),
        .fwd_rd_data(fwd_rd_data), .fwd_rd_data_vld(fwd_rd_data_vld),
        .fwd_done(fwd_done), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_data(input int c, input logic [AW-1:0] a);
        return {32'hC0DE0000 + 32'(c), 24'h000000, a};
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int rr);
        for (int i = 0; i < N; i++) begin
            if (m[(rr + i) % N]) return (rr + i) % N;
        end
        return 0;
    endfunction

    // Per-core memories with a 4-cycle read latency; noise adds stray valids on other cores.
    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (rst) p_en[c] <= 4'b0000;
            else     p_en[c] <= {p_en[c][2:0], core_fwd_rd_en[c]};
            p_addr[c][0] <= core_fwd_addr;
            for (int k = 1; k < 4; k++) p_addr[c][k] <= p_addr[c][k-1];
        end
    end

    always_comb begin
        core_byte_len        = '0;
        core_fwd_rd_data     = '0;
        core_fwd_rd_data_vld = '0;
        for (int c = 0; c < N; c++) begin
            core_byte_len[c*LW +: LW]    = lens[c];
            core_fwd_rd_data[c*DW +: DW] = mem_data(c, p_addr[c][3]);
            core_fwd_rd_data_vld[c]      = p_en[c][3] | (noise && (c != 1));
        end
    end

    // Pulse accounting and routing watch, sampled mid-cycle.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            ack_cnt[c]  <= ack_cnt[c]  + int'(core_rdy_for_fwd_ack[c]);
            done_cnt[c] <= done_cnt[c] + int'(core_fwd_done[c]);
        end
        if ((|core_rdy_for_fwd_ack) && (|core_fwd_done)) overlap <= overlap + 1;
        if (route_chk && ((core_fwd_rd_en & 4'b1101) != 4'b0000)) rogue_en <= rogue_en + 1;
        if (route_chk && core_fwd_rd_en[1]) en_beats <= en_beats + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the request mask to have just been set while the arbiter is idle.
    task automatic grant_phase(output int g);
        exp_t x;
        int   k;
        x.idx = pick(core_rdy_for_fwd, m_rr);
        x.len = int'(lens[x.idx]);
        exp_q.push_back(x);
        k = 0;
        while (!rdy_for_fwd && k < 20) begin
            tick();
            k++;
        end
        x = exp_q.pop_front();
        g = x.idx;
        if (!rdy_for_fwd) begin
            check("grant_timeout", 64'(rdy_for_fwd), 64'd1);
            return;
        end
        check("grant_latency", 64'(k), 64'd1);
        check("grant_idx", 64'(grant_idx), 64'(x.idx));
        check("byte_len", 64'(fwd_byte_len), 64'(x.len));
        for (int c = 0; c < N; c++) begin
            if (c == int'(grant_idx)) waits[c] = 0;
            else if (core_rdy_for_fwd[c]) waits[c]++;
            if (waits[c] > max_wait) max_wait = waits[c];
        end
    endtask

    task automatic ack_phase(input int idx, input int stall);
        repeat (stall) tick();
        rdy_for_fwd_ack = 1'b1;
        #1;
        check("ack_onehot", 64'(core_rdy_for_fwd_ack), 64'd1 << idx);
        check("no_done_at_ack", 64'(core_fwd_done), 64'd0);
        exp_acks[idx]++;
        tick();
        rdy_for_fwd_ack = 1'b0;
        check("busy_not_offer", 64'(rdy_for_fwd), 64'd0);
    endtask

    task automatic done_phase(input int idx, input int busy);
        repeat (busy) tick();
        fwd_done = 1'b1;
        #1;
        check("done_onehot", 64'(core_fwd_done), 64'd1 << idx);
        check("no_ack_at_done", 64'(core_rdy_for_fwd_ack), 64'd0);
        exp_dones[idx]++;
        tick();
        fwd_done = 1'b0;
        m_rr = (idx + 1) % N;
        check("idle_after_done", 64'(rdy_for_fwd), 64'd0);
    endtask

    initial begin
        int g;
        int sent;
        int beats;
        logic [DW-1:0] e;

        rst = 1'b1; core_rdy_for_fwd = '0; rdy_for_fwd_ack = 1'b0; fwd_addr = '0;
        fwd_rd_en = 1'b0; fwd_done = 1'b0; noise = 1'b0; route_chk = 1'b0;
        for (int c = 0; c < N; c++) lens[c] = LW'(20 + c);

        // Reset state, with live-looking forwarder inputs that must stay gated.
        tick(); tick();
        fwd_rd_en = 1'b1; rdy_for_fwd_ack = 1'b1; fwd_done = 1'b1;
        #1;
        check("rst_rdy", 64'(rdy_for_fwd), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_len", 64'(fwd_byte_len), 64'd0);
        check("rst_ack", 64'(core_rdy_for_fwd_ack), 64'd0);
        check("rst_done", 64'(core_fwd_done), 64'd0);
        check("rst_rd_en", 64'(core_fwd_rd_en), 64'd0);
        check("rst_vld", 64'(fwd_rd_data_vld), 64'd0);
        fwd_rd_en = 1'b0; rdy_for_fwd_ack = 1'b0; fwd_done = 1'b0;
        rst = 1'b0;

        // Stray done while idle.
        tick();
        fwd_done = 1'b1;
        #1;
        check("stray_done_idle", 64'(core_fwd_done), 64'd0);
        tick();
        fwd_done = 1'b0;
        check("stray_done_state", 64'(rdy_for_fwd), 64'd0);

        // Withdrawal of core 0 before the ack.
        core_rdy_for_fwd = 4'b0001;
        grant_phase(g);
        core_rdy_for_fwd = 4'b0000;
        tick();
        check("withdraw_idle", 64'(rdy_for_fwd), 64'd0);
        tick();
        check("withdraw_no_ack", 64'(ack_cnt[0]), 64'd0);
        check("withdraw_no_done", 64'(done_cnt[0]), 64'd0);
        core_rdy_for_fwd = 4'b1010;
        grant_phase(g);
        ack_phase(g, 1);
        done_phase(g, 2);

        // Single request: core 2 with length 40.
        lens[2] = LW'(40);
        core_rdy_for_fwd = 4'b0100;
        grant_phase(g);
        ack_phase(g, 0);
        done_phase(g, 3);

        // rr_ptr now 3, so core 3 wins; stray ack in BUSY, then reset mid-packet.
        core_rdy_for_fwd = 4'b1011;
        grant_phase(g);
        ack_phase(g, 0);
        rdy_for_fwd_ack = 1'b1;
        #1;
        check("stray_ack_busy", 64'(core_rdy_for_fwd_ack), 64'd0);
        tick();
        rdy_for_fwd_ack = 1'b0;
        check("stray_ack_state", 64'(rdy_for_fwd), 64'd0);
        fwd_rd_en = 1'b1;
        #1;
        check("busy_rd_en_route", 64'(core_fwd_rd_en), 64'b1000);
        rst = 1'b1; fwd_done = 1'b1; rdy_for_fwd_ack = 1'b1;
        #1;
        check("async_rst_rd_en", 64'(core_fwd_rd_en), 64'd0);
        check("async_rst_done", 64'(core_fwd_done), 64'd0);
        check("async_rst_ack", 64'(core_rdy_for_fwd_ack), 64'd0);
        check("async_rst_grant", 64'(grant_idx), 64'd0);
        check("async_rst_len", 64'(fwd_byte_len), 64'd0);
        fwd_done = 1'b0; rdy_for_fwd_ack = 1'b0; fwd_rd_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_rr = 0;

        // Fairness: all cores request continuously for 8 packets.
        for (int c = 0; c < N; c++) lens[c] = LW'(100 + 7 * c);
        core_rdy_for_fwd = 4'b1111;
        for (int p = 0; p < 8; p++) begin
            grant_phase(g);
            ack_phase(g, p % 2);
            done_phase(g, 1 + (p % 3));
            core_rdy_for_fwd = 4'b1111;
        end

        // Read routing to core 1 with stray valids on the other cores.
        lens[1] = LW'(55);
        core_rdy_for_fwd = 4'b0010;
        grant_phase(g);
        ack_phase(g, 0);
        noise = 1'b1; route_chk = 1'b1; sent = 0; beats = 0;
        for (int cyc = 0; cyc < 30 && (sent < 5 || rd_q.size() > 0); cyc++) begin
            tick();
            if (sent < 5) begin
                fwd_rd_en = 1'b1;
                fwd_addr  = AW'(sent);
                rd_q.push_back(mem_data(1, AW'(sent)));
                sent++;
            end else begin
                fwd_rd_en = 1'b0;
            end
            #1;
            if (fwd_rd_data_vld) begin
                if (rd_q.size() == 0) begin
                    check("rd_spurious_vld", 64'(fwd_rd_data_vld), 64'd0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_data", fwd_rd_data, e);
                    beats++;
                end
            end
        end
        fwd_rd_en = 1'b0;
        fwd_addr  = 8'hA5;
        #1;
        check("addr_broadcast", 64'(core_fwd_addr), 64'hA5);
        check("rd_beats", 64'(beats), 64'd5);
        tick();
        noise = 1'b0; route_chk = 1'b0;
        check("rd_en_only_core1", 64'(rogue_en), 64'd0);
        check("rd_en_core1_beats", 64'(en_beats), 64'd5);
        done_phase(g, 1);

        // Random requests, lengths and stalls.
        core_rdy_for_fwd = '0;
        for (int p = 0; p < 40; p++) begin
            for (int c = 0; c < N; c++) begin
                if (!core_rdy_for_fwd[c] && $urandom_range(0, 1) == 1) begin
                    core_rdy_for_fwd[c] = 1'b1;
                    lens[c] = LW'($urandom_range(16, 79));
                end
            end
            if (core_rdy_for_fwd == '0) begin
                g = int'($urandom_range(0, N - 1));
                core_rdy_for_fwd[g] = 1'b1;
                lens[g] = LW'($urandom_range(16, 79));
            end
            grant_phase(g);
            ack_phase(g, int'($urandom_range(0, 3)));
            core_rdy_for_fwd[g] = 1'b0;
            done_phase(g, int'($urandom_range(0, 4)));
        end

        tick();
        for (int c = 0; c < N; c++) begin
            check("ack_count", 64'(ack_cnt[c]), 64'(exp_acks[c]));
            check("done_count", 64'(done_cnt[c]), 64'(exp_dones[c]));
        end
        check("ack_done_overlap", 64'(overlap), 64'd0);
        check("starvation", 64'(max_wait <= N - 1), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
